hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer side of the forwarding handshake. The forwarding unit consumes the after-bubble indication and register IDs; this block generates the bubbles and stalls that it reacts to.
- Sits beside the ID stage. It detects load-use hazards against the instruction in EX, inserts ID/EX bubbles, flushes IF/ID on taken branches, and freezes the whole pipe while data memory is busy.
- It drives the registered after_bubble flag consumed by the forwarding unit, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 4, register-ID width.
- LOAD_LATENCY, 1, number of bubble cycles inserted per load-use hazard; legal range 1..7.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_src_reg  in  REG_W  source register ID of the instruction in ID.
- id_dst_reg  in  REG_W  second-operand/destination register ID read by the instruction in ID.
- id_uses_src  in  1  ID instruction reads id_src_reg.
- id_uses_dst  in  1  ID instruction reads id_dst_reg.
- ex_valid  in  1  EX holds a real instruction (not a bubble).
- ex_mem_read  in  1  EX instruction is a load.
- ex_dst_reg  in  REG_W  EX instruction write-back register.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write_en  out  1  PC may update.
- ifid_write_en  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID is loaded with a NOP.
- idex_bubble  out  1  ID/EX is loaded with a NOP.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- after_bubble  out  1  registered flag: the ID/EX contents were a bubble inserted last cycle.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write_en=0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, lu_cnt=0, ret_state=RUN, after_bubble=0, stall_cycles=0.
  - Combinational outputs at reset resolve to RUN defaults: pc_write_en=1, ifid_write_en=1, all others 0.
- Load-use hazard (combinational): lu_hz = ex_valid & ex_mem_read & ((id_uses_src & id_src_reg==ex_dst_reg) | (id_uses_dst & id_dst_reg==ex_dst_reg)).
  - Register ID 0 is not special; it compares like any other ID.
- Outputs are Mealy, driven from state plus inputs. States: RUN, LU_STALL, MEM_WAIT.
- Arbitration priority within a cycle: memory wait > branch flush > load-use.
- RUN:
  - mem_req & !mem_ready: pipe_hold=1, pc_write_en=0, ifid_write_en=0, idex_bubble=0. Set ret_state=RUN and go to MEM_WAIT.
  - else if ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write_en=1. Stay in RUN. A coincident lu_hz is ignored, because the ID instruction is being squashed.
  - else if lu_hz: pc_write_en=0, ifid_write_en=0, idex_bubble=1.
    - If LOAD_LATENCY>1, go to LU_STALL with lu_cnt=LOAD_LATENCY-1.
    - Otherwise stay in RUN.
  - else: defaults apply.
- LU_STALL:
  - mem_req & !mem_ready: behave as the RUN memory-wait case. Set ret_state=LU_STALL and go to MEM_WAIT; lu_cnt frozen.
  - else: pc_write_en=0, ifid_write_en=0, idex_bubble=1. Decrement lu_cnt; when lu_cnt==1, go to RUN.
  - ex_branch_taken is ignored in LU_STALL, because EX holds a bubble.
- MEM_WAIT:
  - pipe_hold=1, pc_write_en=0, ifid_write_en=0, no bubble, no flush.
  - On mem_ready=1: outputs for that cycle are still held. Next state=ret_state.
- after_bubble <= idex_bubble & !pipe_hold, registered every cycle.
- stall_cycles increments when pc_write_en=0 and saturates at all-ones (no wrap).
- Reset asserted mid-stall or mid-wait returns to RUN immediately. No pending hazard is remembered.

Decomposition:
- Shared pipeline package holds:
  - state enum (RUN, LU_STALL, MEM_WAIT);
  - REG_W default;
  - NOP encoding used by the stage registers.
- No sub-module is needed, except an optional sat_counter (width-parameterised saturating incrementer) that is reusable elsewhere.

Test Plan:
- Load-use: EX=load to R3, ID reads src R3, LOAD_LATENCY=1 -> one cycle with pc_write_en=0, idex_bubble=1; next cycle after_bubble=1, pipe resumes; stall_cycles=1.
- LOAD_LATENCY=3, load to R5, ID dst R5 -> 3 consecutive bubble cycles, then RUN; after_bubble high for 3 cycles, starting one cycle after the first bubble.
- Branch taken coincident with lu_hz -> ifid_flush=1, idex_bubble=1, pc_write_en=1, no stall; state stays RUN.
- mem_req=1 with mem_ready low for 4 cycles during LU_STALL (lu_cnt=2) -> pipe_hold=1 for 4 cycles, lu_cnt frozen; after mem_ready, LU_STALL resumes and completes its remaining 2 bubble cycles.
- No hazard: ID reads R2, EX loads R7, or ex_valid=0 with ex_dst_reg=R2 -> no stall, all enables 1.
- rst_n pulsed low mid-LU_STALL -> immediately state=RUN, after_bubble=0, stall_cycles=0, pc_write_en=1.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control slice:
// controller state encoding, default register-ID width and the stage NOP.
package hazard_stall_unit_pkg;

  // Default register-ID width used by the ID/EX comparators.
  localparam int REG_W_DEF = 4;

  // Width of the load-use bubble down-counter; covers LOAD_LATENCY 1..7.
  localparam int LU_CNT_W = 3;

  // Instruction word the stage registers load when they are flushed or bubbled.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Stall controller states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Width-parameterised saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count enabled cycles, sticking at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall control beside the ID stage: load-use bubbles, taken-branch
// flushes and whole-pipe freeze while data memory is busy. Also produces the
// registered after_bubble flag for the forwarding unit and a stall counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_src_reg,
  input  logic [REG_W-1:0] id_dst_reg,
  input  logic             id_uses_src,
  input  logic             id_uses_dst,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst_reg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             after_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  hz_state_e           r_state;
  hz_state_e           r_ret_state;
  logic [LU_CNT_W-1:0] r_lu_cnt;
  logic                r_after_bubble;

  logic                w_lu_hz;
  logic                w_mem_stall;

  // Load in EX writing a register the ID instruction reads; ID 0 is ordinary.
  assign w_lu_hz = ex_valid & ex_mem_read &
                   ((id_uses_src & (id_src_reg == ex_dst_reg)) |
                    (id_uses_dst & (id_dst_reg == ex_dst_reg)));

  // Memory access issued but not completing this cycle.
  assign w_mem_stall = mem_req & ~mem_ready;

  // Mealy pipeline controls; priority is memory wait > branch flush > load-use.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pipe_hold     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          pipe_hold     = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
        end else if (ex_branch_taken) begin
          // The ID instruction is squashed, so a coincident hazard is moot.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (w_lu_hz) begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
        end
      end
      LU_STALL: begin
        // EX holds a bubble here, so branch resolution cannot occur.
        if (w_mem_stall) begin
          pipe_hold     = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
        end else begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Held through the completing cycle as well.
        pipe_hold     = 1'b1;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
      end
      default: ;
    endcase
  end

  // Controller state, remaining bubble count and the state to resume after a memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_lu_cnt    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_ret_state <= RUN;
            r_state     <= MEM_WAIT;
          end else if (!ex_branch_taken && w_lu_hz && (LOAD_LATENCY > 1)) begin
            r_lu_cnt <= LU_CNT_W'(LOAD_LATENCY - 1);
            r_state  <= LU_STALL;
          end
        end
        LU_STALL: begin
          if (w_mem_stall) begin
            r_ret_state <= LU_STALL;
            r_state     <= MEM_WAIT;
          end else begin
            r_lu_cnt <= r_lu_cnt - 1'b1;
            if (r_lu_cnt == LU_CNT_W'(1)) begin
              r_state <= RUN;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            r_state <= r_ret_state;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Flag that ID/EX now holds a bubble inserted last cycle (not a frozen one).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_after_bubble <= 1'b0;
    end else begin
      r_after_bubble <= idex_bubble & ~pipe_hold;
    end
  end

  assign after_bubble = r_after_bubble;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (~pc_write_en),
    .o_count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a table of single-cycle RUN-state
// vectors plus hand-written multi-cycle sequences. Three instances share the
// stimulus: LOAD_LATENCY=1, LOAD_LATENCY=3, and a 3-bit counter variant.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  localparam int RW = 4;

  typedef struct packed {
    logic [RW-1:0] src;
    logic [RW-1:0] dst;
    logic          us;
    logic          ud;
    logic          ev;
    logic          emr;
    logic [RW-1:0] ed;
    logic          bt;
    logic          mreq;
    logic          mrdy;
  } stim_t;

  typedef struct {
    string name;
    stim_t s;
    logic  pc;
    logic  ifid;
    logic  fl;
    logic  bub;
    logic  hold;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] id_src_reg, id_dst_reg, ex_dst_reg;
  logic          id_uses_src, id_uses_dst, ex_valid, ex_mem_read;
  logic          ex_branch_taken, mem_req, mem_ready;

  logic          pc_we [3];
  logic          ifid_we [3];
  logic          flush [3];
  logic          bubble [3];
  logic          hold [3];
  logic          ab [3];
  logic [15:0]   sc0, sc1;
  logic [2:0]    sc2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_W(RW), .LOAD_LATENCY(1), .CNT_W(16)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .id_src_reg(id_src_reg), .id_dst_reg(id_dst_reg),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_dst_reg(ex_dst_reg), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write_en(pc_we[0]),
    .ifid_write_en(ifid_we[0]), .ifid_flush(flush[0]), .idex_bubble(bubble[0]),
    .pipe_hold(hold[0]), .after_bubble(ab[0]), .stall_cycles(sc0));

  hazard_stall_unit #(.REG_W(RW), .LOAD_LATENCY(3), .CNT_W(16)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .id_src_reg(id_src_reg), .id_dst_reg(id_dst_reg),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_dst_reg(ex_dst_reg), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write_en(pc_we[1]),
    .ifid_write_en(ifid_we[1]), .ifid_flush(flush[1]), .idex_bubble(bubble[1]),
    .pipe_hold(hold[1]), .after_bubble(ab[1]), .stall_cycles(sc1));

  hazard_stall_unit #(.REG_W(RW), .LOAD_LATENCY(1), .CNT_W(3)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_src_reg(id_src_reg), .id_dst_reg(id_dst_reg),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_dst_reg(ex_dst_reg), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write_en(pc_we[2]),
    .ifid_write_en(ifid_we[2]), .ifid_flush(flush[2]), .idex_bubble(bubble[2]),
    .pipe_hold(hold[2]), .after_bubble(ab[2]), .stall_cycles(sc2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    id_src_reg      = s.src;
    id_dst_reg      = s.dst;
    id_uses_src     = s.us;
    id_uses_dst     = s.ud;
    ex_valid        = s.ev;
    ex_mem_read     = s.emr;
    ex_dst_reg      = s.ed;
    ex_branch_taken = s.bt;
    mem_req         = s.mreq;
    mem_ready       = s.mrdy;
  endtask

  // Drive inputs at the falling edge and settle before comb checks.
  task automatic cyc_begin(input stim_t s);
    @(negedge clk);
    apply(s);
    #1;
  endtask

  // Let the rising edge register state; sample shortly after.
  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb(input string tag, input int i, input logic pc, input logic ifid,
                            input logic fl, input logic bub, input logic hd);
    check({tag, ".pc_write_en"},   32'(pc_we[i]),   32'(pc));
    check({tag, ".ifid_write_en"}, 32'(ifid_we[i]), 32'(ifid));
    check({tag, ".ifid_flush"},    32'(flush[i]),   32'(fl));
    check({tag, ".idex_bubble"},   32'(bubble[i]),  32'(bub));
    check({tag, ".pipe_hold"},     32'(hold[i]),    32'(hd));
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply('0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Hazard stimulus builder: load in EX to 'ed', ID reads src/dst as given.
  function automatic stim_t mk(input logic [RW-1:0] src, input logic [RW-1:0] dst,
                               input logic us, input logic ud, input logic ev,
                               input logic emr, input logic [RW-1:0] ed, input logic bt,
                               input logic mreq, input logic mrdy);
    stim_t s;
    s.src = src; s.dst = dst; s.us = us; s.ud = ud; s.ev = ev;
    s.emr = emr; s.ed = ed; s.bt = bt; s.mreq = mreq; s.mrdy = mrdy;
    return s;
  endfunction

  vec_t  vecs [11];
  stim_t idle;
  stim_t lu3;
  stim_t lu5;
  stim_t mwait;
  stim_t mdone;
  int    exp_stall;

  initial begin
    idle  = '0;
    lu3   = mk(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    lu5   = mk(4'd1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    mwait = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    mdone = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

    //                name            src    dst    us    ud    ev    emr   ed     bt    mreq  mrdy          pc    ifid  fl    bub   hold
    vecs[0]  = '{"no_hz_r2_r7",   mk(4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"ex_invalid",    mk(4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"lu_src_r3",     lu3,                                                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"lu_dst_r5",     lu5,                                                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"match_unused",  mk(4'd3, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"ex_not_load",   mk(4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"lu_r0",         mk(4'd0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"branch_lu",     mk(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{"branch_only",   mk(4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{"mem_rdy_lu",    mk(4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{"mem_rdy_idle",  mdone,                                                            1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state: asserted reset, inputs idle.
    apply('0);
    #3;
    check_comb("rst", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.after_bubble", 32'(ab[0]), 32'd0);
    check("rst.stall_cycles", 32'(sc0), 32'd0);
    check("rst.stall_cycles_sat", 32'(sc2), 32'd0);
    #4;
    rst_n = 1'b1;

    // Table: single-cycle vectors on the LOAD_LATENCY=1 instance (stays in RUN).
    exp_stall = 0;
    for (int i = 0; i < 11; i++) begin
      cyc_begin(vecs[i].s);
      check_comb(vecs[i].name, 0, vecs[i].pc, vecs[i].ifid, vecs[i].fl, vecs[i].bub, vecs[i].hold);
      if (!vecs[i].pc) exp_stall++;
      cyc_end();
      check({vecs[i].name, ".after_bubble"}, 32'(ab[0]), 32'(vecs[i].bub & ~vecs[i].hold));
      check({vecs[i].name, ".stall_cycles"}, 32'(sc0), 32'(exp_stall));
    end

    // LOAD_LATENCY=1: one bubble, then after_bubble and resume.
    do_reset();
    cyc_begin(lu3);
    check_comb("l1_lu", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc_end();
    cyc_begin(idle);
    check("l1_resume.after_bubble", 32'(ab[0]), 32'd1);
    check_comb("l1_resume", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("l1_resume.stall_cycles", 32'(sc0), 32'd1);
    cyc_end();
    check("l1_resume.after_bubble_clr", 32'(ab[0]), 32'd0);

    // LOAD_LATENCY=3: three bubbles, after_bubble trails by one cycle.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc_begin((c == 0) ? lu5 : idle);
      check_comb($sformatf("l3_bub%0d", c), 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc_end();
      check($sformatf("l3_bub%0d.after_bubble", c), 32'(ab[1]), 32'd1);
    end
    cyc_begin(idle);
    check_comb("l3_done", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("l3_done.stall_cycles", 32'(sc1), 32'd3);
    cyc_end();
    check("l3_done.after_bubble", 32'(ab[1]), 32'd0);

    // Branch coincident with a load-use hazard: flush only, no stall entered.
    do_reset();
    cyc_begin(vecs[7].s);
    check_comb("l3_br_lu", 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc_end();
    cyc_begin(idle);
    check_comb("l3_br_next", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("l3_br_next.stall_cycles", 32'(sc1), 32'd0);
    cyc_end();

    // Memory wait inside LU_STALL (lu_cnt=2): freeze, then finish 2 bubbles.
    do_reset();
    cyc_begin(lu3);
    check_comb("mw_first", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc_end();
    for (int c = 0; c < 4; c++) begin
      cyc_begin(mwait);
      check_comb($sformatf("mw_wait%0d", c), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_comb($sformatf("mw_wait%0d_l1", c), 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_end();
      check($sformatf("mw_wait%0d.after_bubble", c), 32'(ab[1]), 32'd0);
    end
    cyc_begin(mdone);
    check_comb("mw_ready", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc_end();
    for (int c = 0; c < 2; c++) begin
      cyc_begin(idle);
      check_comb($sformatf("mw_resume%0d", c), 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (c == 0) check_comb("mw_resume_l1", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc_end();
    end
    cyc_begin(idle);
    check_comb("mw_end", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mw_end.stall_cycles", 32'(sc1), 32'd8);
    cyc_end();

    // Asynchronous reset in the middle of LU_STALL.
    do_reset();
    cyc_begin(lu5);
    cyc_end();
    cyc_begin(idle);
    check("mid.in_stall", 32'(bubble[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_comb("mid_rst", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_rst.after_bubble", 32'(ab[1]), 32'd0);
    check("mid_rst.stall_cycles", 32'(sc1), 32'd0);
    #1;
    rst_n = 1'b1;
    cyc_end();
    cyc_begin(idle);
    check_comb("mid_rst_after", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc_end();

    // Saturation of a 3-bit stall counter under continuous load-use stalls.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc_begin(lu3);
      cyc_end();
      check($sformatf("sat%0d.stall_cycles", c), 32'(sc2), (c < 7) ? 32'(c + 1) : 32'd7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
